// File: rtl/ps2_key_writer_pkg.sv
// Shared definitions for the PS/2 key writer: FSM encoding, the break-prefix
// scancode, RAM word field positions and small packing/parity helpers.
package ps2_key_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_STAT = 3'd6
    } ps2_state_e;

    // Prefix byte a keyboard sends before the scancode of a released key.
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    // Scancode ring word: {23'b0, brk, scancode}
    localparam int KD_CODE_LSB = 0;
    localparam int KD_BRK_BIT  = 8;

    // Status word: {16'b0, err_cnt, wptr}
    localparam int ST_WPTR_LSB = 0;
    localparam int ST_ERR_LSB  = 8;

    // A PS/2 frame is valid when the data byte plus parity bit hold an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

    function automatic logic [31:0] packScan(input logic brk, input logic [7:0] code);
        logic [31:0] w;
        w = 32'd0;
        w[KD_CODE_LSB +: 8] = code;
        w[KD_BRK_BIT]       = brk;
        return w;
    endfunction

    function automatic logic [31:0] packStatus(input logic [7:0] errCnt, input logic [7:0] wptr);
        logic [31:0] w;
        w = 32'd0;
        w[ST_WPTR_LSB +: 8] = wptr;
        w[ST_ERR_LSB  +: 8] = errCnt;
        return w;
    endfunction

endpackage

// File: rtl/ps2_key_writer_sync.sv
// Brings the asynchronous PS/2 clock and data lines into the clk domain and
// produces a one-cycle pulse on each synchronized PS/2 clock falling edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic ps2DataSync,
    output logic ps2ClkFall
);

    logic [1:0] clkSync_r;
    logic [1:0] dataSync_r;
    logic       clkPrev_r;

    // Two-flop synchronizers (idle-high lines reset to 1) plus edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_r  <= 2'b11;
            dataSync_r <= 2'b11;
            clkPrev_r  <= 1'b1;
        end else begin
            clkSync_r  <= {clkSync_r[0], ps2_clk};
            dataSync_r <= {dataSync_r[0], ps2_data};
            clkPrev_r  <= clkSync_r[1];
        end
    end

    assign ps2DataSync = dataSync_r[1];
    assign ps2ClkFall  = clkPrev_r & ~clkSync_r[1];

endmodule

// File: rtl/ps2_key_writer.sv
// PS/2 keyboard receiver that stores scancodes into a RAM ring buffer and
// refreshes a status word after every frame.
// Optional feature: define KEY_BREAK_FILTER_EN to fold the 0xF0 break prefix
// into bit 8 of the following scancode instead of storing it.
module ps2_key_writer
    import ps2_key_writer_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STATUS_ADDR = 48,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] KeyAddr,
    output logic [31:0] KeyData,
    output logic        KeyWe
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e    state_r, nextState_s;
    logic [7:0]    shift_r, shiftNext_s;
    logic [2:0]    bitCnt_r, bitCntNext_s;
    logic          parity_r, parityNext_s;
    logic [TW-1:0] tout_r, toutNext_s;
    logic [PW-1:0] wrPtr_r, wrPtrNext_s;
    logic [7:0]    errCnt_r, errCntNext_s;
    logic          keyWe_r, keyWeNext_s;
    logic [31:0]   keyAddr_r, keyAddrNext_s;
    logic [31:0]   keyData_r, keyDataNext_s;
    logic          dataSync_s, fallEdge_s, tmoHit_s, brkBit_s;

`ifdef KEY_BREAK_FILTER_EN
    logic brk_r, brkNext_s;
    assign brkBit_s = brk_r;
`else
    assign brkBit_s = 1'b0;
`endif

    ps2_sync_edge u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2DataSync (dataSync_s),
        .ps2ClkFall  (fallEdge_s)
    );

    assign tmoHit_s = (tout_r == TW'(TIMEOUT_CYC - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state, frame capture, ring pointer/error bookkeeping and next write port values.
    always_comb begin
        nextState_s   = state_r;
        shiftNext_s   = shift_r;
        bitCntNext_s  = bitCnt_r;
        parityNext_s  = parity_r;
        toutNext_s    = '0;
        wrPtrNext_s   = wrPtr_r;
        errCntNext_s  = errCnt_r;
        keyWeNext_s   = 1'b0;
        keyAddrNext_s = keyAddr_r;
        keyDataNext_s = keyData_r;
`ifdef KEY_BREAK_FILTER_EN
        brkNext_s     = brk_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (fallEdge_s && !dataSync_s) begin
                    nextState_s = ST_START;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Start bit accepted; prepare to collect the data byte.
                bitCntNext_s = 3'd0;
                shiftNext_s  = 8'd0;
                nextState_s  = ST_DATA;
            end
            ST_DATA: begin
                if (fallEdge_s) begin
                    shiftNext_s = {dataSync_s, shift_r[7:1]};
                    if (bitCnt_r == 3'd7) begin
                        nextState_s = ST_PARITY;
                    end else begin
                        bitCntNext_s = bitCnt_r + 3'd1;
                    end
                end else if (tmoHit_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    toutNext_s = tout_r + TW'(1);
                end
            end
            ST_PARITY: begin
                if (fallEdge_s) begin
                    parityNext_s = dataSync_s;
                    nextState_s  = ST_STOP;
                end else if (tmoHit_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    toutNext_s = tout_r + TW'(1);
                end
            end
            ST_STOP: begin
                if (fallEdge_s) begin
                    if (!oddParityOk(shift_r, parity_r) || !dataSync_s) begin
                        errCntNext_s  = (errCnt_r == 8'hFF) ? 8'hFF : errCnt_r + 8'd1;
                        nextState_s   = ST_WR_STAT;
                        keyWeNext_s   = 1'b1;
                        keyAddrNext_s = 32'(STATUS_ADDR);
                        keyDataNext_s = packStatus(errCntNext_s, 8'(wrPtr_r));
                    end
`ifdef KEY_BREAK_FILTER_EN
                    else if (shift_r == KEY_BREAK) begin
                        brkNext_s     = 1'b1;
                        nextState_s   = ST_WR_STAT;
                        keyWeNext_s   = 1'b1;
                        keyAddrNext_s = 32'(STATUS_ADDR);
                        keyDataNext_s = packStatus(errCnt_r, 8'(wrPtr_r));
                    end
`endif
                    else begin
                        nextState_s   = ST_WR_DATA;
                        keyWeNext_s   = 1'b1;
                        keyAddrNext_s = 32'(BASE_ADDR) + 32'(wrPtr_r);
                        keyDataNext_s = packScan(brkBit_s, shift_r);
                    end
                end else if (tmoHit_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    toutNext_s = tout_r + TW'(1);
                end
            end
            ST_WR_DATA: begin
                // Ring wraps naturally since DEPTH is a power of two.
                wrPtrNext_s   = wrPtr_r + PW'(1);
`ifdef KEY_BREAK_FILTER_EN
                brkNext_s     = 1'b0;
`endif
                nextState_s   = ST_WR_STAT;
                keyWeNext_s   = 1'b1;
                keyAddrNext_s = 32'(STATUS_ADDR);
                keyDataNext_s = packStatus(errCnt_r, 8'(wrPtrNext_s));
            end
            ST_WR_STAT: begin
                nextState_s = ST_IDLE;
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= 8'd0;
            bitCnt_r  <= 3'd0;
            parity_r  <= 1'b0;
            tout_r    <= '0;
            wrPtr_r   <= '0;
            errCnt_r  <= 8'd0;
            keyWe_r   <= 1'b0;
            keyAddr_r <= 32'd0;
            keyData_r <= 32'd0;
        end else begin
            shift_r   <= shiftNext_s;
            bitCnt_r  <= bitCntNext_s;
            parity_r  <= parityNext_s;
            tout_r    <= toutNext_s;
            wrPtr_r   <= wrPtrNext_s;
            errCnt_r  <= errCntNext_s;
            keyWe_r   <= keyWeNext_s;
            keyAddr_r <= keyAddrNext_s;
            keyData_r <= keyDataNext_s;
        end
    end

`ifdef KEY_BREAK_FILTER_EN
    // Pending break-prefix flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_r <= 1'b0;
        end else begin
            brk_r <= brkNext_s;
        end
    end
`endif

    assign KeyWe   = keyWe_r;
    assign KeyAddr = keyAddr_r;
    assign KeyData = keyData_r;

endmodule

// File: tb/tb_ps2_key_writer.sv
// Self-checking bench for ps2_key_writer: a frame-level model predicts every
// RAM write, a monitor compares each write, and literal checks pin key cases.
module tb_ps2_key_writer;

    localparam int HALF  = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] KeyAddr;
    logic [31:0] KeyData;
    logic        KeyWe;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        follow;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    int          compared = 0;
    int          failed = 0;
    int          cyc = 0;
    int          lastWeCyc = 0;
    int          mWptr = 0;
    int          mErr = 0;
    bit          mBrk = 1'b0;

    ps2_key_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .KeyAddr  (KeyAddr),
        .KeyData  (KeyData),
        .KeyWe    (KeyWe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame-level model: decide what the RAM must see for one complete frame.
    task automatic model_frame(input logic [7:0] code, input logic par, input logic stop);
        exp_t e;
        bit good;
        good = (^{code, par}) && stop;
        if (!good) begin
            mErr = (mErr < 255) ? mErr + 1 : 255;
            e = '{addr: 32'd48, data: 32'(mErr * 256 + mWptr), follow: 1'b0};
            expQ.push_back(e);
        end else begin
`ifdef KEY_BREAK_FILTER_EN
            if (code == 8'hF0) begin
                mBrk = 1'b1;
                e = '{addr: 32'd48, data: 32'(mErr * 256 + mWptr), follow: 1'b0};
                expQ.push_back(e);
                return;
            end
`endif
            e = '{addr: 32'(32 + mWptr), data: 32'((mBrk ? 256 : 0) + int'(code)), follow: 1'b0};
            expQ.push_back(e);
            mWptr = (mWptr + 1) % DEPTH;
            mBrk = 1'b0;
            e = '{addr: 32'd48, data: 32'(mErr * 256 + mWptr), follow: 1'b1};
            expQ.push_back(e);
        end
    endtask

    // Watches the write port every cycle and checks each write against the model.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (KeyWe === 1'b1) begin
                logAddr.push_back(KeyAddr);
                logData.push_back(KeyData);
                if (expQ.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", KeyAddr, KeyData);
                end else begin
                    e = expQ.pop_front();
                    check("write_addr", KeyAddr, e.addr);
                    check("write_data", KeyData, e.data);
                    if (e.follow) check("status_next_cycle", 32'(cyc - lastWeCyc), 32'd1);
                end
                lastWeCyc = cyc;
            end else if (KeyWe !== 1'b0) begin
                compared++;
                failed++;
                $display("FAIL keywe_known: got %b, expected 0 or 1", KeyWe);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flipPar, input bit badStop, input int nbits);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = code;
        bits[9]   = ~(^code) ^ flipPar;
        bits[10]  = ~badStop;
        if (nbits == 11) model_frame(code, bits[9], bits[10]);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        check("writes_drained", 32'(expQ.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 11);
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_keywe", {31'd0, KeyWe}, 32'd0);
        check("rst_keyaddr", KeyAddr, 32'd0);
        check("rst_keydata", KeyData, 32'd0);
        rst_n = 1'b1;
        mWptr = 0;
        mErr = 0;
        mBrk = 1'b0;
        expQ.delete();
        logAddr.delete();
        logData.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_keywe", {31'd0, KeyWe}, 32'd0);
        check("rst_keyaddr", KeyAddr, 32'd0);
        check("rst_keydata", KeyData, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame 0x1C: data word then status word
        good(8'h1C);
        check("good_1c_count", 32'(logAddr.size()), 32'd2);
        if (logAddr.size() >= 2) begin
            check("good_1c_addr", logAddr[0], 32'd32);
            check("good_1c_data", logData[0], 32'h0000_001C);
            check("good_1c_stat_addr", logAddr[1], 32'd48);
            check("good_1c_stat_data", logData[1], 32'h0000_0001);
        end

        // Bad parity: status only, err_cnt=1
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        drain();
        check("badpar_count", 32'(logAddr.size()), 32'd1);
        if (logAddr.size() >= 1) begin
            check("badpar_addr", logAddr[0], 32'd48);
            check("badpar_data", logData[0], 32'h0000_0100);
        end

        // Framing error on top: err_cnt=2
        send_frame(8'h55, 1'b0, 1'b1, 11);
        drain();
        if (logData.size() >= 2) check("framing_data", logData[1], 32'h0000_0200);

        // A falling edge with data high is not a start bit
        logAddr.delete();
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start_nowrite", 32'(logAddr.size()), 32'd0);

        // 17 frames wrap the ring
        do_reset();
        for (int k = 1; k <= 17; k++) good(8'(k));
        check("wrap_count", 32'(logAddr.size()), 32'd34);
        if (logAddr.size() >= 34) begin
            check("wrap_addr", logAddr[32], 32'd32);
            check("wrap_data", logData[32], 32'h0000_0011);
            check("wrap_stat", logData[33], 32'h0000_0001);
        end

        // Break prefix followed by 0x1C
        do_reset();
        good(8'hF0);
        good(8'h1C);
`ifdef KEY_BREAK_FILTER_EN
        check("brk_count", 32'(logAddr.size()), 32'd3);
        if (logAddr.size() >= 3) begin
            check("brk_stat_addr", logAddr[0], 32'd48);
            check("brk_key_addr", logAddr[1], 32'd32);
            check("brk_key_data", logData[1], 32'h0000_011C);
        end
`else
        check("nobrk_count", 32'(logAddr.size()), 32'd4);
        if (logAddr.size() >= 4) begin
            check("nobrk_f0_data", logData[0], 32'h0000_00F0);
            check("nobrk_1c_addr", logAddr[2], 32'd33);
            check("nobrk_1c_data", logData[2], 32'h0000_001C);
        end
`endif

        // Stalled frame times out and is dropped
        do_reset();
        send_frame(8'h55, 1'b0, 1'b0, 5);
        repeat (50100) @(negedge clk);
        check("stall_nowrite", 32'(logAddr.size()), 32'd0);
        good(8'h2A);
        if (logAddr.size() >= 2) begin
            check("after_tmo_addr", logAddr[0], 32'd32);
            check("after_tmo_data", logData[0], 32'h0000_002A);
        end else begin
            check("after_tmo_count", 32'(logAddr.size()), 32'd2);
        end

        // Reset in the middle of a frame discards it
        send_frame(8'h77, 1'b0, 1'b0, 6);
        do_reset();
        repeat (40) @(negedge clk);
        check("midrst_nowrite", 32'(logAddr.size()), 32'd0);
        good(8'h33);
        if (logAddr.size() >= 2) begin
            check("midrst_next_addr", logAddr[0], 32'd32);
            check("midrst_next_data", logData[0], 32'h0000_0033);
        end else begin
            check("midrst_next_count", 32'(logAddr.size()), 32'd2);
        end

        check("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/ps2_key_writer.md
PS2_KEY_WRITER -- requirements
Module: ps2_key_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32: RAM word index of scancode ring slot 0.
REQ-002 SHALL have parameter DEPTH, default 16 (power of two, 2..256): number of ring slots.
REQ-003 SHALL have parameter STATUS_ADDR, default 48: RAM word index of the status word.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000: clk cycles allowed between PS/2 clock edges inside a frame.
REQ-005 SHALL have port clk  input  1: sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port ps2_clk  input  1: PS/2 device clock, asynchronous.
REQ-008 SHALL have port ps2_data  input  1: PS/2 device data, asynchronous.
REQ-009 SHALL have port KeyAddr  output  32: RAM key-port word address.
REQ-010 SHALL have port KeyData  output  32: RAM key-port write data.
REQ-011 SHALL have port KeyWe  output  1: RAM key-port write enable, one cycle per word.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; a frame bit is sampled on a detected synchronized ps2_clk falling edge.
REQ-013 SHALL run FSM IDLE -> START -> DATA (8 bits, LSB first) -> PARITY -> STOP -> WR_DATA -> WR_STAT -> IDLE.
REQ-014 SHALL leave IDLE only on a falling edge with ps2_data=0; a start edge with data=1 is ignored.
REQ-015 SHALL flag a parity error if the 8 data bits plus the parity bit do not have odd parity.
REQ-016 SHALL flag a framing error if the stop bit is 0.
REQ-017 SHALL, on a good frame, enter WR_DATA the cycle after the stop edge: KeyWe=1, KeyAddr=BASE_ADDR+wptr, KeyData={23'b0,brk,scancode}; then advance wptr modulo DEPTH.
REQ-018 SHALL, in WR_STAT (the next cycle), drive KeyWe=1, KeyAddr=STATUS_ADDR, KeyData={16'b0,err_cnt[7:0],wptr[7:0]} using the updated wptr.
REQ-019 SHALL, on a parity or framing error, skip WR_DATA, increment err_cnt (saturating at 255), and perform WR_STAT only.
REQ-020 SHALL return to IDLE with no write if TIMEOUT_CYC cycles elapse without a falling edge in START..STOP.
REQ-021 SHALL, on ring wrap (wptr DEPTH-1 -> 0), overwrite the oldest slot; the block raises no overflow indication.
REQ-022 SHALL hold KeyWe=0 in all states except WR_DATA and WR_STAT; KeyAddr and KeyData are don't-care when KeyWe=0 but held at their last values.
REQ-023 SHALL ignore PS/2 edges during WR_DATA and WR_STAT; PS/2 frames are at least 10 us apart, so no edge is lost.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, KeyWe=0, KeyAddr=0, KeyData=0, wptr=0, err_cnt=0, brk=0, timeout counter=0, and synchronizers=1.
REQ-025 SHALL discard a partial frame when reset is asserted mid-frame; no write is issued for it after release.

Configuration
REQ-026 SHALL, with KEY_BREAK_FILTER_EN defined, consume a good byte 0xF0 without WR_DATA (WR_STAT still occurs), set brk=1, write the next good byte with bit 8=1, then clear brk.
REQ-027 SHALL, without KEY_BREAK_FILTER_EN, write every good byte (including 0xF0) with bit 8=0 and not implement brk.

Structure
REQ-028 SHALL take its FSM state encoding, the KEY_BREAK constant 8'hF0, and the KeyData/status field positions from the shared package.
REQ-029 SHALL instantiate one sub-module, ps2_sync_edge, that provides the synchronizers and the falling-edge pulse.

Verification
REQ-030 Frame 0x1C with good parity -> one cycle KeyWe at addr 32, data 0x01C; next cycle addr 48, data 0x0001.
REQ-031 Frame 0x1C with bad parity -> single write at addr 48, data 0x0100; no write at addr 32.
REQ-032 17 good frames 0x01..0x11 -> the 17th lands at addr 32 with data 0x011, and the last status is 0x0001.
REQ-033 KEY_BREAK_FILTER_EN defined, frames 0xF0 then 0x1C -> status-only write for the first frame, then addr 32 data 0x11C.
REQ-034 Frame stalled after 4 data bits for 50000 cycles, then a good frame 0x2A -> the first frame is dropped and 0x02A is written at addr 32.
REQ-035 rst_n pulsed low mid-frame -> all outputs 0, no write; the next good frame writes at addr 32.
